// File: rtl/present_pkg.sv
// Shared constants for the PRESENT-80 key schedule: widths, 4-bit S-box
// tables (packed, entry x lives at bits [4x+3:4x]) and FSM state encoding.
package present_pkg;
  localparam int KEY_W = 80;
  localparam int BLK_W = 64;

  // S  = C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2 for inputs 0..F
  localparam logic [63:0] SBOX     = 64'h2174_8FE3_DA09_B65C;
  // S^-1 = 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A for inputs 0..F
  localparam logic [63:0] INV_SBOX = 64'hA970_364B_D21C_8FE5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/present_sbox4.sv
// PRESENT 4-bit S-box; inv selects the inverse table.
module present_sbox4
  import present_pkg::*;
(
  input  logic [3:0] din,
  input  logic       inv,
  output logic [3:0] dout
);
  assign dout = inv ? INV_SBOX[{din, 2'b00} +: 4] : SBOX[{din, 2'b00} +: 4];
endmodule

// File: rtl/present_key_sched.sv
// Iterative PRESENT-80 key schedule. Emits round keys 1..ROUNDS over a
// valid/ready handshake, one key update per accepted key.
// Optional macro PRESENT_KS_REVERSE_EN adds a reverse run (keys ROUNDS..1)
// starting from the final key register of the last forward run.
module present_key_sched
  import present_pkg::*;
#(
  parameter int ROUNDS = 32,
  parameter int CNT_W  = 6
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              dir,
  output logic [BLK_W-1:0]  rk,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic [CNT_W-1:0]  rk_round,
  output logic              busy,
  output logic              done
);
  logic [1:0]       state_q;
  logic [KEY_W-1:0] key_q, key_ld, key_rot, key_fwd, key_nxt;
  logic [CNT_W-1:0] round_q, round_nxt;
  logic [3:0]       sb_fwd;
  logic             last_rk;

  // key_in is presented MSB-first: key_in[0] carries key bit 79
  always_comb begin
    key_ld = '0;
    for (int j = 0; j < KEY_W; j++) key_ld[KEY_W-1-j] = key_in[j];
  end

  // forward update: rotl 61, S-box on the top nibble, XOR round index
  assign key_rot = {key_q[18:0], key_q[79:19]};
  present_sbox4 u_sbox_fwd (.din(key_rot[79:76]), .inv(1'b0), .dout(sb_fwd));
  assign key_fwd = {sb_fwd, key_rot[75:20], key_rot[19:15] ^ 5'(round_q), key_rot[14:0]};

`ifdef PRESENT_KS_REVERSE_EN
  logic             dir_q;
  logic [KEY_W-1:0] last_key, key_x, key_y, key_rev;
  logic [3:0]       sb_inv;

  // inverse update undoes the forward steps in reverse order
  assign key_x = {key_q[79:20], key_q[19:15] ^ 5'(round_q - 1'b1), key_q[14:0]};
  present_sbox4 u_sbox_inv (.din(key_x[79:76]), .inv(1'b1), .dout(sb_inv));
  assign key_y   = {sb_inv, key_x[75:0]};
  assign key_rev = {key_y[60:0], key_y[79:61]};

  assign key_nxt   = dir_q ? key_rev : key_fwd;
  assign round_nxt = dir_q ? round_q - 1'b1 : round_q + 1'b1;
  assign last_rk   = dir_q ? (round_q == CNT_W'(1)) : (round_q == CNT_W'(ROUNDS));

  // run direction and the final forward key, kept for a later reverse run
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      dir_q    <= 1'b0;
      last_key <= '0;
    end else begin
      if (state_q == ST_IDLE && start) dir_q <= dir;
      if (state_q == ST_RUN && rk_ready && last_rk && !dir_q) last_key <= key_q;
    end
  end
`else
  logic unused_dir;
  assign unused_dir = dir;
  assign key_nxt    = key_fwd;
  assign round_nxt  = round_q + 1'b1;
  assign last_rk    = (round_q == CNT_W'(ROUNDS));
`endif

  // control FSM plus key register and round counter
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      round_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
`ifdef PRESENT_KS_REVERSE_EN
          if (dir) begin
            key_q   <= last_key;
            round_q <= CNT_W'(ROUNDS);
          end else begin
            key_q   <= key_ld;
            round_q <= CNT_W'(1);
          end
`else
          key_q   <= key_ld;
          round_q <= CNT_W'(1);
`endif
          state_q <= ST_RUN;
        end
        ST_RUN: if (rk_ready) begin
          if (last_rk) state_q <= ST_DONE;
          else begin
            key_q   <= key_nxt;
            round_q <= round_nxt;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rk       = key_q[79:16];
  assign rk_round = round_q;
  assign rk_valid = (state_q == ST_RUN);
  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
endmodule

// File: tb/tb_present_key_sched.sv
// Directed bench for present_key_sched: reset, known PRESENT vectors,
// back-pressure, ignored start, mid-run reset, back-to-back starts.
module tb_present_key_sched;
  localparam int ROUNDS = 32;
  localparam int CNT_W  = 6;

  logic        sys_clk = 1'b0;
  logic        sys_rst, start, dir, rk_ready;
  logic [79:0] key_in;
  logic [63:0] rk;
  logic        rk_valid, busy, done;
  logic [5:0]  rk_round;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] exp_rk [1:32];
  logic [63:0] got_rk [1:32];
  logic [5:0]  got_rnd[1:32];
  logic        got_done_any;

  present_key_sched #(.ROUNDS(ROUNDS), .CNT_W(CNT_W)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .key_in(key_in),
    .dir(dir), .rk(rk), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_round(rk_round), .busy(busy), .done(done)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] sb(input logic [3:0] x);
    case (x)
      4'h0: sb = 4'hC; 4'h1: sb = 4'h5; 4'h2: sb = 4'h6; 4'h3: sb = 4'hB;
      4'h4: sb = 4'h9; 4'h5: sb = 4'h0; 4'h6: sb = 4'hA; 4'h7: sb = 4'hD;
      4'h8: sb = 4'h3; 4'h9: sb = 4'hE; 4'hA: sb = 4'hF; 4'hB: sb = 4'h8;
      4'hC: sb = 4'h4; 4'hD: sb = 4'h7; 4'hE: sb = 4'h1; default: sb = 4'h2;
    endcase
  endfunction

  // reference key schedule from the user key (key_in[0] = key bit 79)
  task automatic build_model(input logic [79:0] kin);
    logic [79:0] k;
    for (int j = 0; j < 80; j++) k[79-j] = kin[j];
    for (int r = 1; r <= 32; r++) begin
      exp_rk[r] = k[79:16];
      k = {k[18:0], k[79:19]};
      k[79:76] = sb(k[79:76]);
      k[19:15] = k[19:15] ^ 5'(r);
    end
  endtask

  // PRESENT encryption using the keys the DUT emitted
  function automatic logic [63:0] enc(input logic [63:0] pt);
    logic [63:0] s, t, u;
    s = pt;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ got_rk[r];
      for (int n = 0; n < 16; n++) t[4*n +: 4] = sb(s[4*n +: 4]);
      for (int j = 0; j < 63; j++) u[(j*16) % 63] = t[j];
      u[63] = t[63];
      s = u;
    end
    return s ^ got_rk[32];
  endfunction

  task automatic step();
    @(posedge sys_clk); #1;
  endtask

  task automatic do_start(input logic [79:0] k, input logic d);
    key_in = k; dir = d; start = 1'b1;
    step();
    start = 1'b0; key_in = ~k;
  endtask

  // records one full run with rk_ready held high; ends in the DONE cycle
  task automatic collect();
    got_done_any = 1'b0;
    for (int r = 1; r <= 32; r++) begin
      got_rk[r] = rk; got_rnd[r] = rk_round;
      got_done_any = got_done_any | done;
      step();
    end
  endtask

  task automatic wait_round(input int r);
    int c = 0;
    while (rk_round != 6'(r) && c < 60) begin step(); c++; end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; start = 1'b0; dir = 1'b0; rk_ready = 1'b0; key_in = '0;
    step(); step();
    sys_rst = 1'b0;
    n_vec++;
    if ({rk_valid, busy, done} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got %b want 000", {rk_valid, busy, done});
    end
    n_vec++;
    if ({rk_round, rk} !== 70'd0) begin
      n_err++; $display("FAIL reset_regs: got round %0d rk %h want 0/0", rk_round, rk);
    end
  endtask

  task automatic test_zero_key();
    build_model(80'd0);
    rk_ready = 1'b1;
    do_start(80'd0, 1'b0);
    n_vec++;
    if ({rk_valid, busy, rk_round, rk} !== {2'b11, 6'd1, 64'd0}) begin
      n_err++; $display("FAIL zero_rk1: got v%b b%b r%0d %h want v1 b1 r1 0", rk_valid, busy, rk_round, rk);
    end
    collect();
    // done is high in the 33rd cycle counted from the start edge
    n_vec++;
    if ({done, busy, rk_valid, got_done_any} !== 4'b1000) begin
      n_err++; $display("FAIL zero_done_time: got d%b b%b v%b early%b want 1000", done, busy, rk_valid, got_done_any);
    end
    n_vec++;
    if (got_rk[2] !== 64'hC000_0000_0000_0000) begin
      n_err++; $display("FAIL zero_rk2: got %h want c000000000000000", got_rk[2]);
    end
    for (int r = 1; r <= 32; r++) begin
      n_vec++;
      if (got_rk[r] !== exp_rk[r] || got_rnd[r] !== 6'(r)) begin
        n_err++; $display("FAIL zero_seq[%0d]: got r%0d %h want r%0d %h", r, got_rnd[r], got_rk[r], r, exp_rk[r]);
      end
    end
    n_vec++;
    if (enc(64'd0) !== 64'h5579_C138_7B22_8445) begin
      n_err++; $display("FAIL zero_cipher: got %h want 5579c1387b228445", enc(64'd0));
    end
    step();
    n_vec++;
    if (done !== 1'b0 || rk !== exp_rk[32]) begin
      n_err++; $display("FAIL zero_after_done: got d%b %h want d0 %h", done, rk, exp_rk[32]);
    end
  endtask

  task automatic test_allf_key();
    build_model({80{1'b1}});
    do_start({80{1'b1}}, 1'b0);
    collect();
    n_vec++;
    if (got_rk[1] !== 64'hFFFF_FFFF_FFFF_FFFF || got_rk[2] !== 64'h2FFF_FFFF_FFFF_FFFF) begin
      n_err++; $display("FAIL allf_rk12: got %h %h want ffffffffffffffff 2fffffffffffffff", got_rk[1], got_rk[2]);
    end
    for (int r = 1; r <= 32; r++) begin
      n_vec++;
      if (got_rk[r] !== exp_rk[r]) begin
        n_err++; $display("FAIL allf_seq[%0d]: got %h want %h", r, got_rk[r], exp_rk[r]);
      end
    end
    n_vec++;
    if (enc({64{1'b1}}) !== 64'h3333_DCD3_2132_10D2) begin
      n_err++; $display("FAIL allf_cipher: got %h want 3333dcd3213210d2", enc({64{1'b1}}));
    end
    step();
  endtask

  task automatic test_backpressure();
    build_model(80'h0123_4567_89AB_CDEF_FEDC);
    do_start(80'h0123_4567_89AB_CDEF_FEDC, 1'b0);
    wait_round(7);
    rk_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      n_vec++;
      if ({rk_valid, rk_round, rk} !== {1'b1, 6'd7, exp_rk[7]}) begin
        n_err++; $display("FAIL bp_hold[%0d]: got v%b r%0d %h want v1 r7 %h", c, rk_valid, rk_round, rk, exp_rk[7]);
      end
    end
    rk_ready = 1'b1;
    step();
    n_vec++;
    if (rk_round !== 6'd8 || rk !== exp_rk[8]) begin
      n_err++; $display("FAIL bp_resume: got r%0d %h want r8 %h", rk_round, rk, exp_rk[8]);
    end
    wait_round(32);
    step();
    n_vec++;
    if (done !== 1'b1) begin
      n_err++; $display("FAIL bp_done: got %b want 1", done);
    end
    step();
  endtask

  task automatic test_start_ignored();
    build_model(80'hA5A5_0F0F_3C3C_9696_1234);
    do_start(80'hA5A5_0F0F_3C3C_9696_1234, 1'b0);
    wait_round(10);
    key_in = 80'hDEAD_BEEF_0000_1111_2222; start = 1'b1;
    step();
    start = 1'b0;
    n_vec++;
    if ({busy, rk_round, rk} !== {1'b1, 6'd11, exp_rk[11]}) begin
      n_err++; $display("FAIL ign_start: got b%b r%0d %h want b1 r11 %h", busy, rk_round, rk, exp_rk[11]);
    end
    wait_round(32);
    n_vec++;
    if (rk !== exp_rk[32]) begin
      n_err++; $display("FAIL ign_last: got %h want %h", rk, exp_rk[32]);
    end
    step();
    n_vec++;
    if (done !== 1'b1) begin
      n_err++; $display("FAIL ign_done: got %b want 1", done);
    end
    step();
  endtask

  task automatic test_reset_midrun();
    do_start(80'hA5A5_0F0F_3C3C_9696_1234, 1'b0);
    wait_round(15);
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    n_vec++;
    if ({rk_valid, busy, done, rk_round, rk} !== 73'd0) begin
      n_err++; $display("FAIL mid_reset: got v%b b%b d%b r%0d %h want all 0", rk_valid, busy, done, rk_round, rk);
    end
    sys_rst = 1'b1; start = 1'b1; key_in = '0;
    step();
    sys_rst = 1'b0; start = 1'b0;
    n_vec++;
    if (rk_valid !== 1'b0 || rk_round !== 6'd0) begin
      n_err++; $display("FAIL rst_beats_start: got v%b r%0d want v0 r0", rk_valid, rk_round);
    end
    do_start(80'd0, 1'b0);
    step();
    n_vec++;
    if (rk_round !== 6'd2 || rk !== 64'hC000_0000_0000_0000) begin
      n_err++; $display("FAIL mid_restart: got r%0d %h want r2 c000000000000000", rk_round, rk);
    end
    wait_round(32);
    step();
  endtask

  task automatic test_back_to_back();
    // enters here in the DONE cycle of the previous run; start held across
    // DONE (ignored) into IDLE (accepted)
    n_vec++;
    if (done !== 1'b1) begin
      n_err++; $display("FAIL b2b_in_done: got %b want 1", done);
    end
    build_model(80'h1);
    key_in = 80'h1; start = 1'b1;
    step();
    step();
    start = 1'b0;
    n_vec++;
    if ({rk_valid, rk_round, rk} !== {1'b1, 6'd1, 64'h8000_0000_0000_0000}) begin
      n_err++; $display("FAIL b2b_rk1: got v%b r%0d %h want v1 r1 8000000000000000", rk_valid, rk_round, rk);
    end
    step();
    n_vec++;
    if (rk_round !== 6'd2 || rk !== exp_rk[2]) begin
      n_err++; $display("FAIL b2b_rk2: got r%0d %h want r2 %h", rk_round, rk, exp_rk[2]);
    end
    wait_round(32);
    step();
    step();
  endtask

`ifdef PRESENT_KS_REVERSE_EN
  task automatic test_reverse();
    build_model(80'd0);
    do_start(80'd0, 1'b0);
    collect();
    step();
    do_start({80{1'b1}}, 1'b1);
    for (int r = 32; r >= 1; r--) begin
      n_vec++;
      if ({rk_valid, rk_round, rk} !== {1'b1, 6'(r), exp_rk[r]}) begin
        n_err++; $display("FAIL rev_seq[%0d]: got v%b r%0d %h want v1 %h", r, rk_valid, rk_round, rk, exp_rk[r]);
      end
      step();
    end
    n_vec++;
    if (done !== 1'b1 || rk !== 64'd0) begin
      n_err++; $display("FAIL rev_done: got d%b %h want d1 0", done, rk);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_zero_key();
    test_allf_key();
    test_backpressure();
    test_start_ignored();
    test_reset_midrun();
    // test_reset_midrun leaves the DUT in its DONE cycle
    test_back_to_back();
`ifdef PRESENT_KS_REVERSE_EN
    test_reverse();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/present_key_sched.md
Name: present_key_sched

Overview:
- Iterative PRESENT-80 key-schedule engine.
- Sits directly upstream of the PRESENT round datapath and feeds it one 64-bit round key per accepted handshake.
- Takes an 80-bit user key on a start pulse and emits round keys 1..ROUNDS in order.
- Replaces the current practice of presenting a static key vector to the cipher core.

Parameters:
ROUNDS, 32, number of round keys emitted per run; legal range 2..32
CNT_W, 6, width of the round counter and rk_round; must hold ROUNDS

Ports:
sys_clk  input  1  single clock; all logic on its rising edge
sys_rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a run; sampled only in IDLE
key_in  input  80  user key, MSB-first: bit [0] = key bit 79
dir  input  1  0 = forward (rk1 first), 1 = reverse; used only with PRESENT_KS_REVERSE_EN
rk  output  64  current round key = key register bits 79..16
rk_valid  output  1  rk and rk_round are valid
rk_ready  input  1  downstream accepts rk when rk_valid && rk_ready
rk_round  output  CNT_W  index (1..ROUNDS) of the key on rk
busy  output  1  high from the start-acceptance edge until the done edge
done  output  1  one-cycle pulse after the last key is accepted

Behaviour:
- Reset (sys_rst=1 at a clock edge):
  - Go to IDLE.
  - Key register = 0, rk = 0, rk_round = 0.
  - rk_valid = 0, busy = 0, done = 0.
  - Reset overrides any run in progress. No partial output follows reset.
- States:
  - IDLE: rk_valid=0, busy=0.
    - start=1 causes these updates at that edge: load key_in, set rk_round=1, enter RUN.
    - rk_valid=1 from the next cycle. First-key latency is 1 cycle.
  - RUN: rk_valid=1, busy=1.
    - On rk_valid && rk_ready with rk_round < ROUNDS: apply one key update and increment rk_round. The next key is valid the following cycle with no bubble.
    - On a handshake with rk_round == ROUNDS: enter DONE.
    - rk_ready=0 holds rk and rk_round stable. There is no timeout.
  - DONE: lasts one cycle.
    - done=1, rk_valid=0, busy=0.
    - Always returns to IDLE.
    - rk keeps the last key value.
- Forward key update (k = key register, i = rk_round before increment, 1..31), in order:
  - Rotate k left by 61.
  - Replace k[79:76] with S(k[79:76]).
  - k[19:15] ^= i[4:0].
- PRESENT S-box S = C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2 for inputs 0..F.
- Update logic is combinational from the key register. Exactly one round is applied per accepted key.
- start in RUN or DONE is ignored. A new start is accepted in IDLE, including the cycle immediately after DONE.
- start and sys_rst together: reset wins.
- key_in is sampled only on the accepting edge. Later changes have no effect.

Optional Feature:
- Macro: PRESENT_KS_REVERSE_EN.
- Defined:
  - The final 80-bit register after a forward run is saved into last_key (reset 0).
  - start with dir=1 loads last_key instead of key_in and sets rk_round=ROUNDS.
  - Each handshake applies the inverse update: k[19:15] ^= i[4:0] with i = rk_round-1; then S^-1 on k[79:76]; then rotate right by 61. rk_round then decrements.
  - DONE is entered after rk_round==1 is accepted.
  - Keys come out ROUNDS..1 for the decryption datapath.
- Not defined:
  - dir is ignored, no last_key register exists, and only the forward run is supported.

Decomposition:
- Shared package present_pkg: KEY_W=80, BLK_W=64, 4-bit SBOX and INV_SBOX constant tables, FSM state encoding (IDLE, RUN, DONE).
- One sub-module present_sbox4: 4-bit in/out with an inverse select. Instantiated once for forward use and once for inverse use when the macro is on.

Test Plan:
- key_in=0, start, rk_ready=1 → cycle+1: rk=0000_0000_0000_0000, rk_round=1; next: rk=C000_0000_0000_0000, rk_round=2; done pulses once, 33 cycles after the start edge for ROUNDS=32.
- key_in=all-F, start → rk1=FFFF_FFFF_FFFF_FFFF, rk2=2FFF_FFFF_FFFF_FFFF; full run key sequence fed to the round model with plaintext all-F yields 3333_DCD3_2132_10D2.
- Back-pressure: rk_ready low for 5 cycles at rk_round=7 → rk and rk_round stable and rk_valid held at 1; resumes at round 8 on the first ready cycle.
- start pulsed while busy at rk_round=10 with a different key_in → ignored; the sequence continues unchanged; busy stays high.
- sys_rst asserted at rk_round=15 → next cycle rk_valid=0, busy=0, rk=0, rk_round=0; a new start with key 0 reproduces rk2=C000_0000_0000_0000.
- With PRESENT_KS_REVERSE_EN: forward run with key 0, then start with dir=1 → rk_round runs 32..1 and the rk values are exactly the forward list reversed, ending with rk=0 at rk_round=1.
